// File: rtl/bleuart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bleuart_pkg : shared states, default sizes and counter-width helper for the
// BLE UART receive path.                                              Rev 1.0
// ----------------------------------------------------------------------------
package bleuart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam int DATA_BITS_DEF = 8;
   localparam int IDLE_BITS_DEF = 16;
   localparam int WDOG_DEF      = 2048;

   // Bits needed to hold the value max_val itself
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   localparam int WD_W   = cnt_w(WDOG_DEF);
   localparam int IDLE_W = cnt_w(IDLE_BITS_DEF);

endpackage
`default_nettype wire

// File: rtl/bleuart_idle_det.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bleuart_idle_det : counts bit-period ticks of idle line after a delivered
// byte and pulses msg_end once per message.                           Rev 1.0
// ----------------------------------------------------------------------------
module bleuart_idle_det
   import bleuart_pkg::*;
#(
   parameter int IDLE_BITS = IDLE_BITS_DEF,
   parameter int CNT_W     = IDLE_W
) (
   input  logic clk,
   input  logic rst,
   input  logic i_rx,
   input  logic i_lrx,
   input  logic i_idle,
   input  logic i_tick,
   input  logic i_arm_set,
   output logic o_msg_end
);

   localparam logic [CNT_W-1:0] c_SAT = CNT_W'(IDLE_BITS);

   logic [CNT_W-1:0] r_cnt;
   logic             r_arm;
   logic             r_msg_end;
   logic             w_hit;
   logic             w_clr;

   assign w_hit = r_arm & (r_cnt == c_SAT);
   assign w_clr = ~i_idle | ~i_rx | (i_rx != i_lrx);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt     <= '0;
         r_arm     <= 1'b0;
         r_msg_end <= 1'b0;
      end else begin
         // Saturating count keeps a long idle from firing twice
         if (w_clr) begin
            r_cnt <= '0;
         end else if (i_tick && (r_cnt != c_SAT)) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (i_arm_set) begin
            r_arm <= 1'b1;
         end else if (w_hit) begin
            r_arm <= 1'b0;
         end

         r_msg_end <= w_hit;
      end
   end

   assign o_msg_end = r_msg_end;

endmodule
`default_nettype wire

// File: rtl/bleuart_rx_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bleuart_rx_ctrl : BLE UART receive-frame sequencer with valid/ready output.
// Macro BLEUART_RX_PARITY_EN adds an even-parity state and parity_err. Rev 1.0
// ----------------------------------------------------------------------------
module bleuart_rx_ctrl
   import bleuart_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int IDLE_BITS = IDLE_BITS_DEF,
   parameter int WDOG      = WDOG_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 r_tick,
   input  logic                 tick,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 msg_end,
`ifdef BLEUART_RX_PARITY_EN
   output logic                 parity_err,
`endif
   output logic                 busy
);

   localparam int c_BC_W = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS);
   localparam logic [c_BC_W-1:0] c_BC_LAST = c_BC_W'(DATA_BITS - 1);
   // Watchdog counter is never narrower than the default-size counter
   localparam int c_WD_W = (cnt_w(WDOG) > WD_W) ? cnt_w(WDOG) : WD_W;
   localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(WDOG - 1);
`ifdef BLEUART_RX_PARITY_EN
   localparam state_t c_AFTER_DATA = ST_PARITY;
`else
   localparam state_t c_AFTER_DATA = ST_STOP;
`endif

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_lrx;
   logic [c_BC_W-1:0]    r_bitcnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic [c_WD_W-1:0]    r_wd;

   logic                 w_fall;
   logic                 w_in_idle;
   logic                 w_wd_expire;
   logic                 w_shift_en;
   logic                 w_bc_clr;
   logic                 w_stop_ok;
   logic                 w_stop_bad;
`ifdef BLEUART_RX_PARITY_EN
   logic                 r_parity_err;
   logic                 w_par_bad;
`endif

   assign w_fall      = r_lrx & ~rx;
   assign w_in_idle   = (r_state == ST_IDLE);
   assign w_wd_expire = ~w_in_idle & ~r_tick & (r_wd == c_WD_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_bc_clr    = 1'b0;
      w_stop_ok   = 1'b0;
      w_stop_bad  = 1'b0;
`ifdef BLEUART_RX_PARITY_EN
      w_par_bad   = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_fall) begin
               w_state_nxt = ST_START;
               w_bc_clr    = 1'b1;
            end
         end
         ST_START: begin
            if (r_tick) begin
               w_state_nxt = rx ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (r_tick) begin
               w_shift_en = 1'b1;
               if (r_bitcnt == c_BC_LAST) begin
                  w_state_nxt = c_AFTER_DATA;
               end
            end
         end
`ifdef BLEUART_RX_PARITY_EN
         ST_PARITY: begin
            if (r_tick) begin
               w_par_bad   = (rx != (^r_shift));
               w_state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (r_tick) begin
               w_stop_ok   = rx;
               w_stop_bad  = ~rx;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // Expiry only happens in a cycle without r_tick, so no sample is lost
      if (w_wd_expire) begin
         w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_lrx       <= 1'b1;
         r_bitcnt    <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         r_wd        <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_lrx   <= rx;

         if (w_bc_clr) begin
            r_bitcnt <= '0;
         end else if (w_shift_en) begin
            r_bitcnt <= r_bitcnt + 1'b1;
         end

         if (w_shift_en) begin
            r_shift <= {rx, r_shift[DATA_BITS-1:1]};
         end

         if (w_in_idle || r_tick) begin
            r_wd <= '0;
         end else begin
            r_wd <= r_wd + 1'b1;
         end

         r_frame_err <= w_stop_bad | w_wd_expire;
         r_overrun   <= w_stop_ok & r_valid & ~ready;

         // A byte accepted in the same cycle frees the slot for the new one
         if (w_stop_ok && (!r_valid || ready)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && ready) begin
            r_valid <= 1'b0;
         end
      end
   end

`ifdef BLEUART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_parity_err <= 1'b0;
      end else begin
         r_parity_err <= w_par_bad;
      end
   end

   assign parity_err = r_parity_err;
`endif

   bleuart_idle_det #(
      .IDLE_BITS (IDLE_BITS),
      .CNT_W     (cnt_w(IDLE_BITS))
   ) u_idle_det (
      .clk       (clk),
      .rst       (rst),
      .i_rx      (rx),
      .i_lrx     (r_lrx),
      .i_idle    (w_in_idle),
      .i_tick    (tick),
      .i_arm_set (w_stop_ok),
      .o_msg_end (msg_end)
   );

   assign data      = r_data;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = ~w_in_idle;

endmodule
`default_nettype wire

// File: tb/tb_bleuart_rx_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bleuart_rx_ctrl : randomized frames against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_bleuart_rx_ctrl;

   localparam int BP     = 16;
   localparam int WDOG_T = 100;
   localparam int IDLE_B = 16;
   localparam int K_FERR = 1;
   localparam int K_OVR  = 2;
   localparam int K_MSG  = 3;
   localparam int K_PERR = 4;

   logic       clk    = 1'b0;
   logic       rst    = 1'b0;
   logic       rx     = 1'b1;
   logic       r_tick = 1'b0;
   logic       tick   = 1'b0;
   logic       ready  = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic       msg_end;
   logic       busy;
`ifdef BLEUART_RX_PARITY_EN
   logic       parity_err;
`endif

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_bytes[$];
   int         exp_pulses[$];
   bit         m_pending = 1'b0;
   bit         m_arm     = 1'b0;

   always #5 clk = ~clk;

   bleuart_rx_ctrl #(
      .DATA_BITS (8),
      .IDLE_BITS (IDLE_B),
      .WDOG      (WDOG_T)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .r_tick     (r_tick),
      .tick       (tick),
      .data       (data),
      .valid      (valid),
      .ready      (ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .msg_end    (msg_end),
`ifdef BLEUART_RX_PARITY_EN
      .parity_err (parity_err),
`endif
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic pop_pulse(input int kind);
      if (exp_pulses.size() == 0) chk("pulse_unexpected", 32'(kind), 32'd0);
      else                        chk("pulse_kind", 32'(kind), 32'(exp_pulses.pop_front()));
   endtask

   // Monitor: every accepted byte and every pulse is matched against the model queues
   always @(negedge clk) begin
      if (rst) begin
         if (valid && ready) begin
            if (exp_bytes.size() == 0) chk("byte_unexpected", 32'(data), 32'h100);
            else                       chk("byte_data", 32'(data), 32'(exp_bytes.pop_front()));
         end
`ifdef BLEUART_RX_PARITY_EN
         if (parity_err) pop_pulse(K_PERR);
`endif
         if (frame_err) pop_pulse(K_FERR);
         if (overrun)   pop_pulse(K_OVR);
         if (msg_end)   pop_pulse(K_MSG);
      end
   end

   // One bit period: boundary tick at cycle 0, mid-bit sample at BP/2
   task automatic bit_period(input logic b, input bit glitch);
      for (int c = 0; c < BP; c++) begin
         @(posedge clk); #1;
         if (c == 0) rx = b;
         if (glitch && c == 3) rx = 1'b1;
         tick   = (c == 0);
         r_tick = (c == BP / 2);
      end
   endtask

   // kind 0: frame, 1: false start glitch, 2: line held low with no ticks
   task automatic do_item(input int kind, input logic [7:0] b, input logic stop_b,
                          input logic rdy, input int gap);
`ifdef BLEUART_RX_PARITY_EN
      logic pf;
      pf = ($urandom_range(0, 3) == 0);
`endif
      if (rdy) m_pending = 1'b0;
      ready = rdy;
      case (kind)
         0: begin
`ifdef BLEUART_RX_PARITY_EN
            if (pf) exp_pulses.push_back(K_PERR);
`endif
            if (!stop_b) begin
               exp_pulses.push_back(K_FERR);
            end else begin
               m_arm = 1'b1;
               if (rdy || !m_pending) begin
                  exp_bytes.push_back(b);
                  if (!rdy) m_pending = 1'b1;
               end else begin
                  exp_pulses.push_back(K_OVR);
               end
            end
            bit_period(1'b0, 1'b0);
            for (int i = 0; i < 8; i++) bit_period(b[i], 1'b0);
`ifdef BLEUART_RX_PARITY_EN
            bit_period((^b) ^ pf, 1'b0);
`endif
            bit_period(stop_b, 1'b0);
         end
         1: bit_period(1'b0, 1'b1);
         default: begin
            exp_pulses.push_back(K_FERR);
            for (int c = 0; c < WDOG_T + 10; c++) begin
               @(posedge clk); #1;
               rx = 1'b0; tick = 1'b0; r_tick = 1'b0;
            end
         end
      endcase
      if (gap >= IDLE_B + 4 && m_arm) begin
         exp_pulses.push_back(K_MSG);
         m_arm = 1'b0;
      end
      for (int i = 0; i < gap; i++) bit_period(1'b1, 1'b0);
      @(negedge clk);
      chk("busy_after_item", 32'(busy), 32'd0);
      chk("pulses_drained", 32'(exp_pulses.size()), 32'd0);
      if (rdy) chk("bytes_drained", 32'(exp_bytes.size()), 32'd0);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int         k;
      int         kind;
      int         g;
      logic [7:0] b;
      logic       sb;
      logic       rd;

      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({data, valid, frame_err, overrun, msg_end, busy}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Idle line without any byte must stay silent
      for (int i = 0; i < 20; i++) bit_period(1'b1, 1'b0);
      @(negedge clk);
      chk("idle_no_msg", 32'(exp_pulses.size()), 32'd0);

      do_item(0, 8'hA5, 1'b1, 1'b1, 20);
      do_item(1, 8'h00, 1'b1, 1'b1, 3);
      do_item(0, 8'h00, 1'b0, 1'b1, 3);
      do_item(0, 8'h11, 1'b1, 1'b0, 2);
      do_item(0, 8'h22, 1'b1, 1'b0, 2);
      do_item(0, 8'h41, 1'b1, 1'b1, 20);
      do_item(2, 8'h00, 1'b1, 1'b1, 2);

      // Reset in the middle of 0x5A, then a clean 0x3C
      bit_period(1'b0, 1'b0);
      b = 8'h5A;
      for (int i = 0; i < 3; i++) bit_period(b[i], 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; rx = 1'b1; tick = 1'b0; r_tick = 1'b0;
      repeat (3) @(negedge clk);
      chk("outputs_in_reset", 32'({data, valid, frame_err, overrun, msg_end, busy}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      m_arm = 1'b0;
      m_pending = 1'b0;
      do_item(0, 8'h3C, 1'b1, 1'b1, 3);

      for (int n = 0; n < 25; n++) begin
         k    = int'($urandom_range(0, 9));
         kind = (k == 0) ? 1 : ((k == 1) ? 2 : 0);
         b    = 8'($urandom);
         sb   = (k == 2) ? 1'b0 : 1'b1;
         rd   = ($urandom_range(0, 3) != 0);
         g    = ($urandom_range(0, 2) == 0) ? 20 : int'($urandom_range(1, 10));
         do_item(kind, b, sb, rd, g);
      end

      ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("final_bytes_drained", 32'(exp_bytes.size()), 32'd0);
      chk("final_pulses_drained", 32'(exp_pulses.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
